// File: rtl/sh_reg_pkg.sv
// Shared definitions for the sh_reg AXI4-Lite peripheral: register map,
// response codes, FSM state types and the byte-strobe merge helper.
package sh_reg_pkg;

    localparam logic [2:0] REG_SCRATCH0 = 3'd0;
    localparam logic [2:0] REG_SCRATCH1 = 3'd1;
    localparam logic [2:0] REG_SCRATCH2 = 3'd2;
    localparam logic [2:0] REG_SCRATCH3 = 3'd3;
    localparam logic [2:0] REG_SHIFT    = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    // WR_INIT/RD_INIT hold all readies low for the first cycle after reset.
    typedef enum logic [1:0] {
        WR_INIT = 2'd0,
        WR_IDLE = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_INIT = 2'd0,
        RD_IDLE = 2'd1,
        RD_RESP = 2'd2
    } rd_state_t;

    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sh_reg_axil_if.sv
// AXI4-Lite link between the master VIP and the sh_reg responder.
// Handshake: a transfer happens on a rising edge where VALID and READY are both 1;
// VALID and its payload hold until that edge, and READY may not depend on a future transfer.
interface sh_reg_axil_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/sh_reg_shifter.sv
// 32-bit serial-in shift register with parallel load and a wrapping shift counter.
module sh_reg_shifter #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        din,
    input  logic        load,
    input  logic [31:0] load_data,
    output logic [31:0] q,
    output logic        dout,
    output logic [31:0] count
);

    // A load suppresses the shift in the same cycle, so the count only sees real shifts.
    always_ff @(posedge clock) begin
        if (reset) begin
            q     <= '0;
            count <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (en) begin
            q     <= MSB_FIRST ? {q[30:0], din} : {din, q[31:1]};
            count <= count + 32'd1;
        end
    end

    assign dout = MSB_FIRST ? q[31] : q[0];

endmodule

// File: rtl/sh_reg_axil_slave.sv
// AXI4-Lite responder for the sh_reg peripheral: four scratch words, a shift
// register loadable over the bus, and a read-only shift counter.
module sh_reg_axil_slave
    import sh_reg_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter bit SHIFT_MSB_FIRST    = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    sh_reg_axil_if.slave        s_axi,
    input  logic                sh_en,
    input  logic                sh_din,
    output logic                sh_dout,
    output logic [31:0]         sh_q,
    output wr_state_t           wr_state_dbg,
    output rd_state_t           rd_state_dbg
);

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic                            aw_held, w_held;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;
    logic                            aw_fire, w_fire, wr_commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    logic [2:0]                      wr_idx, rd_idx;
    logic                            ar_fire;
    logic [31:0]                     rd_mux, rdata_q;
    logic [31:0]                     scratch [4];
    logic [31:0]                     sh_count;
    logic                            sh_load;
    logic                            unused_bits;

    // ---------------- write path ----------------
    assign aw_fire = (wr_state == WR_IDLE) && !aw_held && s_axi.S_AXI_AWVALID;
    assign w_fire  = (wr_state == WR_IDLE) && !w_held  && s_axi.S_AXI_WVALID;

    // A beat arriving this cycle is used directly so the commit needs no extra cycle.
    assign wr_addr = aw_held ? aw_addr_q : s_axi.S_AXI_AWADDR;
    assign wr_data = w_held  ? w_data_q  : s_axi.S_AXI_WDATA;
    assign wr_strb = w_held  ? w_strb_q  : s_axi.S_AXI_WSTRB;
    assign wr_idx  = wr_addr[4:2];

    always_comb begin
        wr_next             = wr_state;
        wr_commit           = 1'b0;
        s_axi.S_AXI_AWREADY = 1'b0;
        s_axi.S_AXI_WREADY  = 1'b0;
        s_axi.S_AXI_BVALID  = 1'b0;
        case (wr_state)
            WR_INIT: wr_next = WR_IDLE;
            WR_IDLE: begin
                s_axi.S_AXI_AWREADY = !aw_held;
                s_axi.S_AXI_WREADY  = !w_held;
                if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    wr_commit = 1'b1;
                    wr_next   = WR_RESP;
                end
            end
            WR_RESP: begin
                s_axi.S_AXI_BVALID = 1'b1;
                if (s_axi.S_AXI_BREADY) wr_next = WR_IDLE;
            end
            default: wr_next = WR_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state  <= WR_INIT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            wr_state <= wr_next;
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi.S_AXI_AWADDR;
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.S_AXI_WDATA;
                    w_strb_q <= s_axi.S_AXI_WSTRB;
                end
            end
        end
    end

    assign s_axi.S_AXI_BRESP = RESP_OKAY;

    // ---------------- register file ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) scratch[i] <= '0;
        end else if (wr_commit && !wr_idx[2]) begin
            scratch[wr_idx[1:0]] <= wstrb_merge(scratch[wr_idx[1:0]], wr_data, wr_strb);
        end
    end

    assign sh_load = wr_commit && (wr_idx == REG_SHIFT);

    sh_reg_shifter #(.MSB_FIRST(SHIFT_MSB_FIRST)) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .en        (sh_en),
        .din       (sh_din),
        .load      (sh_load),
        .load_data (wstrb_merge(sh_q, wr_data, wr_strb)),
        .q         (sh_q),
        .dout      (sh_dout),
        .count     (sh_count)
    );

    // ---------------- read path ----------------
    assign ar_fire = (rd_state == RD_IDLE) && s_axi.S_AXI_ARVALID;
    assign rd_idx  = s_axi.S_AXI_ARADDR[4:2];

    always_comb begin
        rd_mux = '0;
        if (!rd_idx[2]) begin
            rd_mux = scratch[rd_idx[1:0]];
        end else begin
            case (rd_idx)
                REG_SHIFT:  rd_mux = sh_q;
                REG_STATUS: rd_mux = sh_count;
                default:    rd_mux = '0;
            endcase
        end
    end

    always_comb begin
        rd_next             = rd_state;
        s_axi.S_AXI_ARREADY = 1'b0;
        s_axi.S_AXI_RVALID  = 1'b0;
        case (rd_state)
            RD_INIT: rd_next = RD_IDLE;
            RD_IDLE: begin
                s_axi.S_AXI_ARREADY = 1'b1;
                if (s_axi.S_AXI_ARVALID) rd_next = RD_RESP;
            end
            RD_RESP: begin
                s_axi.S_AXI_RVALID = 1'b1;
                if (s_axi.S_AXI_RREADY) rd_next = RD_IDLE;
            end
            default: rd_next = RD_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state <= RD_INIT;
            rdata_q  <= '0;
        end else begin
            rd_state <= rd_next;
            if (ar_fire) rdata_q <= rd_mux;
        end
    end

    assign s_axi.S_AXI_RDATA = rdata_q;
    assign s_axi.S_AXI_RRESP = RESP_OKAY;

    assign wr_state_dbg = wr_state;
    assign rd_state_dbg = rd_state;

    // Protection bits and byte offsets carry no meaning for word registers.
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_ARADDR[1:0], wr_addr[1:0]};

endmodule
